// File: rtl/sevenseg_digit_scanner_pkg.sv
// Shared constants for the seven-segment digit scanner.
// Anodes and the decimal point are active low.
package sevenseg_digit_scanner_pkg;

   localparam int unsigned DefRefreshDiv  = 100000;
   localparam int unsigned DefGuardCycles = 2;

   localparam logic AnodeOff = 1'b1;
   localparam logic DpOff    = 1'b1;

endpackage

// File: rtl/sevenseg_digit_scanner_prescaler.sv
// Slot prescaler: counts 0..Div-1 while enabled, holds otherwise.
// tick_o flags the edge on which the count wraps.
module sevenseg_digit_scanner_prescaler
   import sevenseg_digit_scanner_pkg::*;
#(
   parameter int unsigned Div = DefRefreshDiv,
   localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   output logic [CntW-1:0] count_o,
   output logic            tick_o
);

   logic [CntW-1:0] count_q, count_d;

   assign tick_o  = en_i && (count_q == CntW'(Div - 1));
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = tick_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sevenseg_digit_scanner.sv
// Time-multiplexed scan controller for a common-anode hex display with
// guard blanking, per-digit blank/DP and leading-zero suppression.
module sevenseg_digit_scanner
   import sevenseg_digit_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = DefRefreshDiv,
   parameter int unsigned GUARD_CYCLES = DefGuardCycles,
   localparam int unsigned SelW = $clog2(NUM_DIGITS),
   localparam int unsigned CntW = $clog2(REFRESH_DIV)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Enable,
   input  logic [4*NUM_DIGITS-1:0] Value,
   input  logic [NUM_DIGITS-1:0]   Blank,
   input  logic [NUM_DIGITS-1:0]   DPIn,
   input  logic                    LZSuppress,
   output logic [3:0]              HexVal,
   output logic [NUM_DIGITS-1:0]   An,
   output logic                    DP,
   output logic [SelW-1:0]         DigitSel,
   output logic                    ScanTick
);

   logic [CntW-1:0] cnt;
   logic            wrap;

   sevenseg_digit_scanner_prescaler #(
      .Div(REFRESH_DIV)
   ) u_prescaler (
      .clk_i  (Clk),
      .rst_i  (Reset),
      .en_i   (Enable),
      .count_o(cnt),
      .tick_o (wrap)
   );

   logic [SelW-1:0]             digit_q, digit_d;
   logic                        tick_q;
   logic [NUM_DIGITS-1:0][3:0]  value_q;
   logic [NUM_DIGITS-1:0]       blank_q, dpsnap_q;
   logic                        lz_q;
   logic                        load_pend_q;
   logic                        frame_load;
   logic [NUM_DIGITS-1:0]       supp;
   logic                        zero_above;
   logic                        lit;
   logic [NUM_DIGITS-1:0]       an_q, an_d;
   logic                        dp_q, dp_d;
   logic [3:0]                  hex_q, hex_d;

   // The first edge after reset also loads a frame so the display lights
   // in the very first slot instead of waiting a whole frame.
   assign frame_load = load_pend_q || (wrap && (digit_q == SelW'(NUM_DIGITS - 1)));

   always_comb begin
      digit_d = digit_q;
      if (wrap) begin
         digit_d = (digit_q == SelW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
      end
   end

   always_comb begin
      supp       = '0;
      zero_above = lz_q;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (value_q[i] == 4'h0);
         supp[i]    = zero_above;
      end
   end

   always_comb begin
      lit = Enable && (cnt >= CntW'(GUARD_CYCLES)) && !blank_q[digit_q] && !supp[digit_q];
      an_d = {NUM_DIGITS{AnodeOff}};
      if (lit) begin
         an_d[digit_q] = ~AnodeOff;
      end
      dp_d  = (lit && dpsnap_q[digit_q]) ? ~DpOff : DpOff;
      hex_d = value_q[digit_q];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         digit_q     <= '0;
         tick_q      <= 1'b0;
         value_q     <= '0;
         blank_q     <= '1;
         dpsnap_q    <= '0;
         lz_q        <= 1'b0;
         load_pend_q <= 1'b1;
         an_q        <= {NUM_DIGITS{AnodeOff}};
         dp_q        <= DpOff;
         hex_q       <= 4'h0;
      end else begin
         digit_q     <= digit_d;
         tick_q      <= wrap;
         load_pend_q <= 1'b0;
         if (frame_load) begin
            value_q  <= Value;
            blank_q  <= Blank;
            dpsnap_q <= DPIn;
            lz_q     <= LZSuppress;
         end
         an_q  <= an_d;
         dp_q  <= dp_d;
         hex_q <= hex_d;
      end
   end

   assign HexVal   = hex_q;
   assign An       = an_q;
   assign DP       = dp_q;
   assign DigitSel = digit_q;
   assign ScanTick = tick_q;

endmodule

// File: tb/tb_sevenseg_digit_scanner.sv
// Randomised bench for sevenseg_digit_scanner (4 digits, 8-cycle slot, 2 guard cycles)
// with a slot-count behavioural model and directed literal checks.
module tb_sevenseg_digit_scanner;

   localparam int Nd  = 4;
   localparam int Div = 8;
   localparam int Grd = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Enable;
   logic [15:0] Value;
   logic [3:0]  Blank;
   logic [3:0]  DPIn;
   logic        LZSuppress;
   logic [3:0]  HexVal;
   logic [3:0]  An;
   logic        DP;
   logic [1:0]  DigitSel;
   logic        ScanTick;

   int n_vec = 0;
   int n_err = 0;

   sevenseg_digit_scanner #(
      .NUM_DIGITS  (Nd),
      .REFRESH_DIV (Div),
      .GUARD_CYCLES(Grd)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Enable    (Enable),
      .Value     (Value),
      .Blank     (Blank),
      .DPIn      (DPIn),
      .LZSuppress(LZSuppress),
      .HexVal    (HexVal),
      .An        (An),
      .DP        (DP),
      .DigitSel  (DigitSel),
      .ScanTick  (ScanTick)
   );

   always #5 Clk = ~Clk;

   // Model: position in the scan is just the number of enabled edges since reset.
   int          m_edges;
   bit          m_pend;
   logic [15:0] s_val;
   logic [3:0]  s_blank, s_dp;
   bit          s_lz;
   int          m_cnt, m_dig;
   logic [15:0] m_above;
   logic [3:0]  exp_an, exp_hex;
   logic        exp_dp, exp_tick;
   logic [1:0]  exp_sel;

   task automatic model_reset();
      m_edges  = 0;
      m_pend   = 1'b1;
      s_val    = 16'h0;
      s_blank  = 4'hF;
      s_dp     = 4'h0;
      s_lz     = 1'b0;
      exp_an   = 4'hF;
      exp_dp   = 1'b1;
      exp_hex  = 4'h0;
      exp_sel  = 2'd0;
      exp_tick = 1'b0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge Clk or posedge Reset);
         if (Reset) begin
            model_reset();
         end else begin
            m_cnt   = m_edges % Div;
            m_dig   = (m_edges / Div) % Nd;
            m_above = s_val >> (4 * m_dig);
            exp_hex = m_above[3:0];
            exp_an  = 4'hF;
            exp_dp  = 1'b1;
            if (Enable && m_cnt >= Grd && !s_blank[m_dig] &&
                !(s_lz && m_dig > 0 && m_above == 16'h0)) begin
               exp_an[m_dig] = 1'b0;
               exp_dp        = !s_dp[m_dig];
            end
            exp_tick = Enable && (m_cnt == Div - 1);
            if (m_pend || (Enable && m_cnt == Div - 1 && m_dig == Nd - 1)) begin
               s_val   = Value;
               s_blank = Blank;
               s_dp    = DPIn;
               s_lz    = LZSuppress;
            end
            m_pend = 1'b0;
            if (Enable) m_edges++;
            exp_sel = 2'((m_edges / Div) % Nd);
         end
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         if (Reset === 1'b0) begin
            n_vec++;
            if ({An, DP, HexVal, DigitSel, ScanTick} !== {exp_an, exp_dp, exp_hex, exp_sel, exp_tick})
            begin
               n_err++;
               $display("FAIL cycle t=%0t An=%b/%b DP=%b/%b Hex=%h/%h Sel=%0d/%0d Tick=%b/%b",
                        $time, An, exp_an, DP, exp_dp, HexVal, exp_hex, DigitSel, exp_sel,
                        ScanTick, exp_tick);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Stops at the negedge just after the edge where the scan wrapped to digit 0.
   task automatic sync_frame();
      int k;
      k = 0;
      do begin
         @(negedge Clk);
         k++;
      end while (!(ScanTick === 1'b1 && DigitSel === 2'd0) && k < 80);
      if (k >= 80) begin
         n_vec++;
         n_err++;
         $display("FAIL sync_frame: no frame wrap within %0d cycles", k);
      end
   endtask

   task automatic check_frame(input string tag, input logic [15:0] an4,
                              input logic [15:0] hex4, input logic [3:0] dp4);
      for (int d = 0; d < Nd; d++) begin
         repeat ((d == 0) ? Grd + 1 : Div) @(negedge Clk);
         chk($sformatf("%s_an_d%0d", tag, d), 32'(An), 32'(an4[4*d +: 4]));
         chk($sformatf("%s_hex_d%0d", tag, d), 32'(HexVal), 32'(hex4[4*d +: 4]));
         chk($sformatf("%s_dp_d%0d", tag, d), 32'(DP), 32'(dp4[d]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int dis_left;

   initial begin
      Reset      = 1'b1;
      Enable     = 1'b1;
      Value      = 16'h12AB;
      Blank      = 4'h0;
      DPIn       = 4'h0;
      LZSuppress = 1'b0;
      repeat (3) @(negedge Clk);
      chk("reset_an", 32'(An), 32'hF);
      chk("reset_hex", 32'(HexVal), 32'h0);
      chk("reset_dp", 32'(DP), 32'h1);
      chk("reset_sel", 32'(DigitSel), 32'h0);
      chk("reset_tick", 32'(ScanTick), 32'h0);
      Reset = 1'b0;

      // Edge n below counts rising edges since reset release.
      repeat (2) @(negedge Clk);
      chk("guard_e2_an", 32'(An), 32'hF);
      repeat (1) @(negedge Clk);
      chk("e3_an", 32'(An), 32'hE);
      chk("e3_hex", 32'(HexVal), 32'hB);
      repeat (5) @(negedge Clk);
      chk("e8_tick", 32'(ScanTick), 32'h1);
      chk("e8_sel", 32'(DigitSel), 32'h1);
      chk("e8_an", 32'(An), 32'hE);
      repeat (1) @(negedge Clk);
      chk("e9_an", 32'(An), 32'hF);
      chk("e9_tick", 32'(ScanTick), 32'h0);
      repeat (2) @(negedge Clk);
      chk("e11_an", 32'(An), 32'hD);
      chk("e11_hex", 32'(HexVal), 32'hA);
      repeat (8) @(negedge Clk);
      chk("e19_an", 32'(An), 32'hB);
      chk("e19_hex", 32'(HexVal), 32'h2);
      repeat (1) @(negedge Clk);
      Value = 16'h3456;
      repeat (7) @(negedge Clk);
      chk("e27_an", 32'(An), 32'h7);
      chk("e27_hex_old", 32'(HexVal), 32'h1);
      repeat (8) @(negedge Clk);
      chk("e35_hex_new", 32'(HexVal), 32'h6);
      repeat (8) @(negedge Clk);
      chk("e43_hex_new", 32'(HexVal), 32'h5);
      repeat (8) @(negedge Clk);
      chk("e51_hex_new", 32'(HexVal), 32'h4);
      repeat (8) @(negedge Clk);
      chk("e59_hex_new", 32'(HexVal), 32'h3);
      chk("e59_an", 32'(An), 32'h7);

      Value      = 16'h0050;
      LZSuppress = 1'b1;
      sync_frame();
      check_frame("lz0050", 16'hFFDE, 16'h0050, 4'hF);
      Value = 16'h0000;
      sync_frame();
      check_frame("lz0000", 16'hFFFE, 16'h0000, 4'hF);

      Value      = 16'h12AB;
      LZSuppress = 1'b0;
      DPIn       = 4'b0100;
      Blank      = 4'b0001;
      sync_frame();
      check_frame("dpblank", 16'h7BDF, 16'h12AB, 4'b1011);

      Blank = 4'h0;
      DPIn  = 4'h0;
      sync_frame();
      repeat (4) @(negedge Clk);
      Enable = 1'b0;
      repeat (20) @(negedge Clk);
      chk("dis_an", 32'(An), 32'hF);
      chk("dis_dp", 32'(DP), 32'h1);
      chk("dis_sel", 32'(DigitSel), 32'h0);
      chk("dis_tick", 32'(ScanTick), 32'h0);
      Enable = 1'b1;
      repeat (3) @(negedge Clk);
      chk("reen_sel_held", 32'(DigitSel), 32'h0);
      chk("reen_no_tick", 32'(ScanTick), 32'h0);
      repeat (1) @(negedge Clk);
      chk("reen_tick", 32'(ScanTick), 32'h1);
      chk("reen_sel", 32'(DigitSel), 32'h1);

      dis_left = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge Clk);
         if ($urandom_range(0, 15) == 0)
            Value = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         if ($urandom_range(0, 19) == 0)
            Blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 19) == 0) DPIn = 4'($urandom);
         if ($urandom_range(0, 29) == 0) LZSuppress = ~LZSuppress;
         if (dis_left > 0) begin
            dis_left--;
            Enable = (dis_left == 0);
         end else if ($urandom_range(0, 59) == 0) begin
            dis_left = $urandom_range(1, 25);
            Enable   = 1'b0;
         end
      end

      Enable     = 1'b1;
      Value      = 16'h12AB;
      Blank      = 4'h0;
      DPIn       = 4'h0;
      LZSuppress = 1'b0;
      repeat (5) @(negedge Clk);
      @(posedge Clk);
      #3;
      Reset = 1'b1;
      #1;
      chk("areset_an", 32'(An), 32'hF);
      chk("areset_hex", 32'(HexVal), 32'h0);
      chk("areset_sel", 32'(DigitSel), 32'h0);
      chk("areset_tick", 32'(ScanTick), 32'h0);
      chk("areset_dp", 32'(DP), 32'h1);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      chk("rel_guard_an", 32'(An), 32'hF);
      repeat (1) @(negedge Clk);
      chk("rel_first_an", 32'(An), 32'hE);
      chk("rel_first_hex", 32'(HexVal), 32'hB);
      repeat (40) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
